ram_dual_rw_ctrl: RTL and testbench
===================================

# ram_dual_rw_ctrl

Single-clock sequencer that drives both ports of the 64×8 pseudo-dual-port RAM. It writes a deterministic pattern through the write port, reads every location back through the read port, and checks the returned words. It sits directly in front of the RAM: its A-side outputs feed the write port, its B-side outputs feed the read port, and it consumes the registered read data. Its status outputs (busy, done, error flag, mismatch count) go to LEDs or a top-level debug probe.

## Interface
- AW, 6, address width; must satisfy MD ≤ 2^AW
- DW, 8, data width
- MD, 64, number of locations exercised (addresses 0..MD-1)
- SEED, 8'h5A, pattern offset; expected word at addr k = (k + SEED) mod 2^DW
---
- clk  in  1  single clock; both RAM ports are clocked from it
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin a write/read/check pass
- ena  out  1  RAM write-port enable
- wea  out  1  RAM write enable
- addra  out  AW  RAM write address
- dina  out  DW  RAM write data
- enb  out  1  RAM read-port enable
- addrb  out  AW  RAM read address
- doutb  in  DW  RAM read data; registered, valid one cycle after enb
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle pulse at the end of a pass
- err  out  1  sticky mismatch flag for the current pass
- err_cnt  out  AW+1  number of mismatching words in the current pass

## Operation
- FSM states: IDLE, WRITE, READ, FLUSH, DONE.
- IDLE: start=1 moves the FSM to WRITE and clears the address counter, err and err_cnt.
- WRITE: drives ena=wea=1, addra=cnt, dina=cnt+SEED (truncated to DW). cnt counts 0..MD-1. When cnt==MD-1, the FSM goes to READ and cnt returns to 0.
- READ: drives enb=1, addrb=cnt. cnt counts 0..MD-1. When cnt==MD-1, the FSM goes to FLUSH.
- Compare pipeline: rd_vld is enb delayed one cycle; rd_addr is addrb delayed one cycle. When rd_vld=1 and doutb ≠ rd_addr+SEED, err is set and err_cnt is incremented.
- FLUSH: one cycle that compares the last read word. All RAM enables are low. The FSM then goes to DONE.
- DONE: done=1 for one cycle, then the FSM returns to IDLE.
- err and err_cnt hold their values from DONE until the next accepted start.
- err_cnt cannot overflow because MD ≤ 2^AW < 2^(AW+1).
- start is ignored in every state other than IDLE.
- In IDLE, FLUSH and DONE, all RAM-side outputs (ena, wea, enb, addra, addrb, dina) are 0.

## Timing
- Reset (async assert, synchronous release): state=IDLE, cnt=0, rd_vld=0, and every output (ena, wea, addra, dina, enb, addrb, busy, done, err, err_cnt) is 0.
- Reset asserted mid-pass: the pass is abandoned immediately and no done pulse is produced. RAM contents are not cleared.
- start sampled high in IDLE at edge T:
  - WRITE occupies cycles T+1..T+MD.
  - READ occupies cycles T+MD+1..T+2MD.
  - FLUSH is cycle T+2MD+1.
  - done is high in cycle T+2MD+2 (T+130 for MD=64).
  - busy is high from T+1 through T+2MD+2.
- Compare timing: the word read at cycle c is checked at the edge ending cycle c+1. The final err and err_cnt values are therefore stable in the cycle where done=1.
- A start pulse coincident with done is ignored. A new start is accepted from the following IDLE cycle.
- Address wrap: cnt never exceeds MD-1. When MD < 2^AW, addresses MD..2^AW-1 are never touched.

## Configuration
- RAM_DUAL_CHECK_EN defined: the compare pipeline, err and err_cnt are built as described above.
- RAM_DUAL_CHECK_EN undefined: the compare logic is omitted, and err and err_cnt are tied to 0. The FSM, the read sweep and all cycle timing (including FLUSH and done) are unchanged.

## Test plan
- Clean pass: reset, release, pulse start with an ideal RAM model attached → addra steps 0..63 with dina 0x5A..0x99; addrb steps 0..63; done at T+130; err=0, err_cnt=0.
- Corrupted word: the RAM model returns 0x00 for addr 5 → err=1, err_cnt=1 at done. A second clean pass clears both to 0.
- All-wrong readback: the RAM model returns ~expected for every word → err_cnt=64 (7'h40) at done. Confirms the count does not wrap.
- start while busy: pulse start at T+10 and T+70 → both ignored; exactly one done, still at T+130.
- Reset mid-WRITE: assert rst_n=0 at T+20 → all outputs read 0 immediately and no done appears. A fresh start then completes normally.
- Check disabled: compile without RAM_DUAL_CHECK_EN and use the corrupted-word model → done still at T+130; err=0, err_cnt=0.

Source files
------------

// File: rtl/ram_dual_rw_ctrl.sv
// Write/read/check sequencer for a pseudo-dual-port RAM: fills every location with a
// seeded ramp, reads it back and counts mismatches when RAM_DUAL_CHECK_EN is defined.
module ram_dual_rw_ctrl #(
    parameter int unsigned AW = 6,
    parameter int unsigned DW = 8,
    parameter int unsigned MD = 64,
    parameter logic [DW-1:0] SEED = 8'h5A
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          start_i,
    output logic          ena_o,
    output logic          wea_o,
    output logic [AW-1:0] addra_o,
    output logic [DW-1:0] dina_o,
    output logic          enb_o,
    output logic [AW-1:0] addrb_o,
    input  logic [DW-1:0] doutb_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o,
    output logic [AW:0]   err_cnt_o
);

    typedef enum logic [2:0] {StIdle, StWrite, StRead, StFlush, StDone} state_e;

    localparam logic [AW-1:0] CntLast = AW'(MD - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          cnt_last;
    logic          accept;

    assign cnt_last = (cnt_q == CntLast);
    assign accept   = (state_q == StIdle) && start_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StWrite;
                    cnt_d   = '0;
                end
            end
            StWrite: begin
                if (cnt_last) begin
                    state_d = StRead;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            StRead: begin
                if (cnt_last) begin
                    state_d = StFlush;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            StFlush: state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ena_o   = 1'b0;
        wea_o   = 1'b0;
        addra_o = '0;
        dina_o  = '0;
        enb_o   = 1'b0;
        addrb_o = '0;
        busy_o  = (state_q != StIdle);
        done_o  = (state_q == StDone);
        case (state_q)
            StWrite: begin
                ena_o   = 1'b1;
                wea_o   = 1'b1;
                addra_o = cnt_q;
                dina_o  = DW'(cnt_q) + SEED;
            end
            StRead: begin
                enb_o   = 1'b1;
                addrb_o = cnt_q;
            end
            default: ;
        endcase
    end

`ifdef RAM_DUAL_CHECK_EN
    logic          rd_vld_q;
    logic [AW-1:0] rd_addr_q;
    logic          err_q, err_d;
    logic [AW:0]   err_cnt_q, err_cnt_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_vld_q  <= 1'b0;
            rd_addr_q <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            rd_vld_q  <= enb_o;
            rd_addr_q <= addrb_o;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // rd_vld_q is never high in IDLE, so clear and count cannot collide.
    always_comb begin
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        if (accept) begin
            err_d     = 1'b0;
            err_cnt_d = '0;
        end else if (rd_vld_q && (doutb_i != (DW'(rd_addr_q) + SEED))) begin
            err_d     = 1'b1;
            err_cnt_d = err_cnt_q + (AW + 1)'(1);
        end
    end

    assign err_o     = err_q;
    assign err_cnt_o = err_cnt_q;
`else
    logic unused_inputs;

    assign unused_inputs = ^{doutb_i, accept};
    assign err_o         = 1'b0;
    assign err_cnt_o     = '0;
`endif

endmodule

// File: tb/tb_ram_dual_rw_ctrl.sv
// Bench for ram_dual_rw_ctrl: RAM model with fault modes, queue scoreboard of expected
// write/read port activity, and directed passes covering timing, errors and reset.
module tb_ram_dual_rw_ctrl;

    localparam int MD   = 64;
    localparam int SEED = 'h5A;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       start_i = 1'b0;
    logic       ena_o, wea_o, enb_o, busy_o, done_o, err_o;
    logic [5:0] addra_o, addrb_o;
    logic [7:0] dina_o;
    logic [7:0] doutb_i = 8'h00;
    logic [6:0] err_cnt_o;

    int checks = 0;
    int failures = 0;
    int done_seen = 0;
    int mode = 0;
    logic [7:0] mem [MD];

    int wa_q[$];
    int wd_q[$];
    int ra_q[$];

    ram_dual_rw_ctrl dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .start_i  (start_i),
        .ena_o    (ena_o),
        .wea_o    (wea_o),
        .addra_o  (addra_o),
        .dina_o   (dina_o),
        .enb_o    (enb_o),
        .addrb_o  (addrb_o),
        .doutb_i  (doutb_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .err_o    (err_o),
        .err_cnt_o(err_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // RAM model: mode 1 corrupts address 5, mode 2 inverts every word.
    always @(posedge clk_i) begin
        if (ena_o && wea_o) mem[addra_o] <= dina_o;
        if (enb_o) begin
            if (mode == 1 && addrb_o == 6'd5) doutb_i <= 8'h00;
            else if (mode == 2)               doutb_i <= ~mem[addrb_o];
            else                              doutb_i <= mem[addrb_o];
        end
    end

    // Port monitor: pops the scoreboard on every enabled cycle, requires zeros otherwise.
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (done_o) done_seen++;
            if (ena_o) begin
                if (wa_q.size() == 0) begin
                    check("write_unexpected", 32'd1, 32'd0);
                end else begin
                    check("write_addr", 32'(addra_o), 32'(wa_q.pop_front()));
                    check("write_data", 32'(dina_o), 32'(wd_q.pop_front()));
                    check("write_we", 32'(wea_o), 32'd1);
                end
            end else begin
                check("wport_idle", {17'd0, wea_o, addra_o, dina_o}, 32'd0);
            end
            if (enb_o) begin
                if (ra_q.size() == 0) check("read_unexpected", 32'd1, 32'd0);
                else check("read_addr", 32'(addrb_o), 32'(ra_q.pop_front()));
                check("rw_exclusive", 32'(ena_o), 32'd0);
            end else begin
                check("rport_idle", 32'(addrb_o), 32'd0);
            end
        end
    end

    function automatic int exp_err_cnt(input int m);
`ifdef RAM_DUAL_CHECK_EN
        if (m == 1) return 1;
        if (m == 2) return MD;
        return 0;
`else
        return 0;
`endif
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_a"}, {16'd0, ena_o, wea_o, addra_o, dina_o}, 32'd0);
        check({tag, "_b"}, {15'd0, enb_o, addrb_o, busy_o, done_o, err_o, err_cnt_o}, 32'd0);
    endtask

    // One pass: xs pulses extra starts at k=10/70, sd starts again in the done cycle,
    // rst_k>0 asserts reset in cycle k of the pass.
    task automatic run_pass(input int m, input bit xs, input bit sd, input int rst_k);
        int got;
        int d0;
        int ec;
        got = 0;
        ec  = exp_err_cnt(m);
        mode = m;
        wa_q.delete();
        wd_q.delete();
        ra_q.delete();
        for (int i = 0; i < MD; i++) begin
            wa_q.push_back(i);
            wd_q.push_back((i + SEED) & 'hFF);
            ra_q.push_back(i);
        end
        d0 = done_seen;
        @(negedge clk_i);
        start_i = 1'b1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk_i);
            start_i = xs && (k == 10 || k == 70);
            if (k == 1) begin
                check("err_cleared", 32'(err_o), 32'd0);
                check("err_cnt_cleared", 32'(err_cnt_o), 32'd0);
            end
            if (rst_k == k) begin
                rst_ni = 1'b0;
                #1;
                check_all_zero("reset_mid_pass");
                break;
            end
            check("busy_in_pass", 32'(busy_o), 32'd1);
            if (done_o) begin
                got = k;
                check("done_latency", 32'(k), 32'(2 * MD + 2));
                check("err_at_done", 32'(err_o), 32'(ec != 0));
                check("err_cnt_at_done", 32'(err_cnt_o), 32'(ec));
                start_i = sd;
                break;
            end
        end
        if (rst_k > 0) begin
            repeat (3) @(negedge clk_i);
            check_all_zero("reset_held");
            rst_ni = 1'b1;
            wa_q.delete();
            wd_q.delete();
            ra_q.delete();
            repeat (5) @(negedge clk_i);
            check("no_done_after_reset", 32'(done_seen - d0), 32'd0);
            check("idle_after_reset", 32'(busy_o), 32'd0);
        end else begin
            if (got == 0) check("done_timeout", 32'd0, 32'd1);
            @(negedge clk_i);
            start_i = 1'b0;
            check("idle_after_done", {30'd0, busy_o, done_o}, 32'd0);
            check("err_cnt_held", 32'(err_cnt_o), 32'(ec));
            @(negedge clk_i);
            check("start_at_done_ignored", 32'(busy_o), 32'd0);
            check("err_held", 32'(err_o), 32'(ec != 0));
            repeat (3) @(negedge clk_i);
            check("one_done_pulse", 32'(done_seen - d0), 32'd1);
            check("sb_write_drained", 32'(wa_q.size()), 32'd0);
            check("sb_read_drained", 32'(ra_q.size()), 32'd0);
        end
    endtask

    initial begin
        for (int i = 0; i < MD; i++) mem[i] = 8'h00;
        #1;
        check_all_zero("reset_state");
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        check_all_zero("after_release");

        run_pass(0, 1'b0, 1'b0, 0);
        run_pass(1, 1'b0, 1'b1, 0);
        run_pass(0, 1'b0, 1'b0, 0);
        run_pass(2, 1'b0, 1'b0, 0);
        run_pass(0, 1'b1, 1'b0, 0);
        run_pass(0, 1'b0, 1'b0, 20);
        run_pass(0, 1'b0, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
